// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control for load-use, dmem wait,
// dmem timeout, trap and taken-branch events. Optional perf counters.
//
// Ports:
//   clk, nrst (sync, active-low)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source operands
//   ex_rd/m1_rd, ex_is_load/m1_is_load   : producers in EX / M1
//   m2_mem_op, dmem_ready                : M2 dmem access handshake
//   ex_branch_taken, m2_trap_req         : redirect events
//   *_stall, *_flush, m2_wb_bubble       : pipeline register controls
//   pc_sel_trap, mem_timeout             : trap redirect / timeout pulse
//   stall_cnt, flush_cnt                 : perf counters
// Macro PIPE_HAZ_PERF_EN enables the counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  m1_rd,
  input  logic        ex_is_load,
  input  logic        m1_is_load,
  input  logic        m2_mem_op,
  input  logic        dmem_ready,
  input  logic        ex_branch_taken,
  input  logic        m2_trap_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_m1_stall,
  output logic        m1_m2_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_m1_flush,
  output logic        m1_m2_flush,
  output logic        m2_wb_bubble,
  output logic        pc_sel_trap,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] wcnt, wcnt_n;

  logic in_run, in_wait;
  logic freeze, tout;
  logic hz_rs1, hz_rs2, hz;

  assign in_run  = (state == RUN);
  assign in_wait = (state == MEM_WAIT);

  assign freeze = (in_run & m2_mem_op & ~dmem_ready)
                | (in_wait & ~dmem_ready & (wcnt < TO_LIM));
  assign tout   = in_wait & ~dmem_ready & (wcnt == TO_LIM);

  // x0 is hardwired zero, so it never carries a dependency
  assign hz_rs1 = id_use_rs1 & (id_rs1 != 5'd0)
                & (((id_rs1 == ex_rd) & ex_is_load)
                 | ((id_rs1 == m1_rd) & m1_is_load));
  assign hz_rs2 = id_use_rs2 & (id_rs2 != 5'd0)
                & (((id_rs2 == ex_rd) & ex_is_load)
                 | ((id_rs2 == m1_rd) & m1_is_load));
  assign hz     = hz_rs1 | hz_rs2;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    wcnt_n       = 8'd0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_m1_stall  = 1'b0;
    m1_m2_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_m1_flush  = 1'b0;
    m1_m2_flush  = 1'b0;
    m2_wb_bubble = 1'b0;
    pc_sel_trap  = 1'b0;
    mem_timeout  = 1'b0;
    if (!nrst) begin
      state_n = RUN;
    end else begin
      case (state)
        TRAP: begin
          pc_sel_trap = 1'b1;
          if_id_flush = 1'b1;
          state_n     = RUN;
        end
        RUN, MEM_WAIT: begin
          state_n = RUN;
          if (tout) begin
            mem_timeout  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_m1_flush  = 1'b1;
            m1_m2_flush  = 1'b1;
            m2_wb_bubble = 1'b1;
            state_n      = TRAP;
          end else if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_m1_stall  = 1'b1;
            m1_m2_stall  = 1'b1;
            m2_wb_bubble = 1'b1;
            state_n      = MEM_WAIT;
            // count starts at zero on the cycle MEM_WAIT is entered
            wcnt_n       = in_wait ? wcnt + 8'd1 : 8'd0;
          end else if (in_run & m2_trap_req) begin
            // trapping instruction itself retires: no WB bubble
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_m1_flush = 1'b1;
            m1_m2_flush = 1'b1;
            state_n     = TRAP;
          end else if (in_run & ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (pc_stall && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (id_ex_flush && flush_q != 32'hFFFF_FFFF)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Output vector order: pcS ifS idS exS m1S | ifF idF exF m1F | bub trap to.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, m1_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_is_load, m1_is_load;
  logic        m2_mem_op, dmem_ready;
  logic        ex_branch_taken, m2_trap_req;
  logic        pc_stall, if_id_stall, id_ex_stall;
  logic        ex_m1_stall, m1_m2_stall;
  logic        if_id_flush, id_ex_flush, ex_m1_flush, m1_m2_flush;
  logic        m2_wb_bubble, pc_sel_trap, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .nrst(nrst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .m1_rd(m1_rd),
    .ex_is_load(ex_is_load), .m1_is_load(m1_is_load),
    .m2_mem_op(m2_mem_op), .dmem_ready(dmem_ready),
    .ex_branch_taken(ex_branch_taken), .m2_trap_req(m2_trap_req),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_m1_stall(ex_m1_stall),
    .m1_m2_stall(m1_m2_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_m1_flush(ex_m1_flush), .m1_m2_flush(m1_m2_flush),
    .m2_wb_bubble(m2_wb_bubble), .pc_sel_trap(pc_sel_trap),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  localparam logic [11:0] NONE   = 12'h000;
  localparam logic [11:0] FREEZE = 12'b11111_0000_100;
  localparam logic [11:0] LU     = 12'b11000_0100_000;
  localparam logic [11:0] BR     = 12'b00000_1100_000;
  localparam logic [11:0] TRAPF  = 12'b00000_1111_000;
  localparam logic [11:0] TOUT   = 12'b00000_1111_101;
  localparam logic [11:0] TRAPST = 12'b00000_1000_010;

  logic [11:0] outv;
  assign outv = {pc_stall, if_id_stall, id_ex_stall, ex_m1_stall,
                 m1_m2_stall, if_id_flush, id_ex_flush, ex_m1_flush,
                 m1_m2_flush, m2_wb_bubble, pc_sel_trap, mem_timeout};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sample mid-low-phase, then advance one full clock
  task automatic cyc(input string tag, input logic [11:0] exp);
    #1;
    check(tag, {20'd0, outv}, {20'd0, exp});
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; m1_rd = 5'd0;
    ex_is_load = 1'b0; m1_is_load = 1'b0;
    m2_mem_op = 1'b0; dmem_ready = 1'b0;
    ex_branch_taken = 1'b0; m2_trap_req = 1'b0;
  endtask

  initial begin
    idle();
    nrst = 1'b0;
    m2_mem_op = 1'b1;
    m2_trap_req = 1'b1;
    @(negedge clk);
    cyc("rst_outs", NONE);
    check("rst_scnt", stall_cnt, 32'd0);
    check("rst_fcnt", flush_cnt, 32'd0);
    idle();
    nrst = 1'b1;
    cyc("idle", NONE);

    // load-use on EX producer
    ex_is_load = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cyc("lu_ex", LU);
    idle();
    cyc("lu_gone", NONE);
    ex_is_load = 1'b1; id_use_rs1 = 1'b1;
    cyc("lu_x0_ex", NONE);
    m1_is_load = 1'b1;
    cyc("lu_x0_m1", NONE);
    idle();

    // load-use on M1 producer via rs2
    m1_is_load = 1'b1; m1_rd = 5'd9;
    id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    cyc("lu_m1_rs2", LU);
    id_use_rs2 = 1'b0;
    cyc("lu_nouse", NONE);
    id_use_rs2 = 1'b1; m1_is_load = 1'b0;
    cyc("lu_noload", NONE);
    idle();

    // branch beats load-use
    ex_is_load = 1'b1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    cyc("br_lu", BR);
    idle();

    // dmem wait: 3 frozen cycles then clean completion
    m2_mem_op = 1'b1;
    cyc("dw_1", FREEZE);
    cyc("dw_2", FREEZE);
    cyc("dw_3", FREEZE);
    dmem_ready = 1'b1;
    cyc("dw_done", NONE);
    m2_mem_op = 1'b0; dmem_ready = 1'b0;
    cyc("dw_run", NONE);

    // timeout with MEM_TIMEOUT=4
    m2_mem_op = 1'b1;
    for (int i = 1; i <= 5; i++)
      cyc($sformatf("to_frz%0d", i), FREEZE);
    cyc("to_pulse", TOUT);
    cyc("to_trap", TRAPST);
    idle();
    cyc("to_after", NONE);

    // trap + branch + load-use together
    ex_is_load = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    ex_branch_taken = 1'b1; m2_trap_req = 1'b1;
    cyc("tr_all", TRAPF);
    cyc("tr_state", TRAPST);
    idle();
    cyc("tr_after", NONE);

    // freeze outranks trap
    m2_mem_op = 1'b1; m2_trap_req = 1'b1;
    cyc("frz_trap", FREEZE);
    m2_trap_req = 1'b0; dmem_ready = 1'b1;
    cyc("frz_rel", NONE);
    idle();

    // reset in MEM_WAIT abandons it
    m2_mem_op = 1'b1;
    cyc("rw_1", FREEZE);
    cyc("rw_2", FREEZE);
    nrst = 1'b0;
    cyc("rw_rst", NONE);
    nrst = 1'b1;
    m2_mem_op = 1'b0;
    cyc("rw_run", NONE);

    // ten load-use stall cycles for the counters
    ex_is_load = 1'b1; ex_rd = 5'd12;
    id_rs2 = 5'd12; id_use_rs2 = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc($sformatf("cnt_lu%0d", i), LU);
    idle();
    #1;
`ifdef PIPE_HAZ_PERF_EN
    check("stall_cnt", stall_cnt, 32'd10);
    check("flush_cnt", flush_cnt, 32'd10);
`else
    check("stall_cnt", stall_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning max consecutive dmem wait cycles before timeout (range 1..255).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- nrst  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5 each  ID-stage source register indices
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- ex_rd, m1_rd  in  5 each  destination of EX / M1 instruction
- ex_is_load, m1_is_load  in  1 each  EX / M1 instruction is a load
- m2_mem_op  in  1  M2 instruction is a dmem access
- dmem_ready  in  1  dmem completes the M2 access this cycle
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- m2_trap_req  in  1  M2 instruction raises a trap
- pc_stall, if_id_stall, id_ex_stall, ex_m1_stall, m1_m2_stall  out  1 each  hold the PC / named pipeline register
- if_id_flush, id_ex_flush, ex_m1_flush, m1_m2_flush  out  1 each  load a bubble into the named register
- m2_wb_bubble  out  1  M2/WB register loads zeros (wb_src=0)
- pc_sel_trap  out  1  PC mux selects trap vector
- mem_timeout  out  1  one-cycle dmem timeout pulse
- stall_cnt, flush_cnt  out  32 each  performance counters

Function
REQ-003 SHALL implement FSM states RUN, MEM_WAIT, TRAP and an 8-bit wait counter wcnt.
REQ-004 All outputs SHALL be combinational from state, wcnt and inputs; all are 0 unless a rule below asserts them.
REQ-005 freeze = (RUN & m2_mem_op & ~dmem_ready) | (MEM_WAIT & ~dmem_ready & wcnt<MEM_TIMEOUT).
REQ-006 On freeze: assert pc_stall, all four *_stall and m2_wb_bubble, and no flush; next state MEM_WAIT; wcnt increments in MEM_WAIT and clears on entry.
REQ-007 In MEM_WAIT with dmem_ready=1: no freeze; the op advances; next state RUN.
REQ-008 In MEM_WAIT with wcnt==MEM_TIMEOUT and dmem_ready=0: pulse mem_timeout, assert all four *_flush and m2_wb_bubble; next state TRAP.
REQ-009 RUN, no freeze, m2_trap_req=1: assert all four *_flush; m2_wb_bubble=0 so the trapping instruction retires; next state TRAP.
REQ-010 TRAP lasts exactly one cycle: assert pc_sel_trap and if_id_flush; ignore all other inputs; next state RUN.
REQ-011 RUN, no freeze/trap, ex_branch_taken=1: assert if_id_flush and id_ex_flush; suppress load-use detection.
REQ-012 Load-use hazard: for each source s with id_use_s=1 and id_rs_s!=0, a hazard exists if (id_rs_s==ex_rd & ex_is_load) or (id_rs_s==m1_rd & m1_is_load).
REQ-013 On a load-use hazard with no higher-priority event: assert pc_stall, if_id_stall and id_ex_flush.
REQ-014 Priority SHALL be: timeout > freeze > trap > branch > load-use.
REQ-015 Register x0 SHALL never cause a hazard.

Reset
REQ-016 While nrst=0 at a rising edge: state<=RUN, wcnt<=0, stall_cnt<=0, flush_cnt<=0.
REQ-017 While nrst=0, all combinational outputs SHALL be forced to 0.
REQ-018 Reset asserted in MEM_WAIT or TRAP SHALL abandon that state with no pulse generated.

Configuration
REQ-019 With PIPE_HAZ_PERF_EN defined:
- stall_cnt increments on each cycle with pc_stall=1.
- flush_cnt increments on each cycle with id_ex_flush=1.
- Both counters saturate at 32'hFFFFFFFF.
REQ-020 With PIPE_HAZ_PERF_EN undefined: the ports remain, are tied to 0, and no counter flops are inferred.

Verification
REQ-021 Load-use: ex_is_load=1, ex_rd=5; id_rs1=5, id_use_rs1=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle. Same stimulus with ex_rd=0, id_rs1=0 -> no stall.
REQ-022 Dmem wait: m2_mem_op=1, dmem_ready=0 for 3 cycles then 1 -> freeze and m2_wb_bubble for 3 cycles; the 4th cycle is clean; state returns to RUN.
REQ-023 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout pulse on the 6th cycle, then pc_sel_trap=1 on the 7th cycle.
REQ-024 Simultaneous m2_trap_req, ex_branch_taken and load-use hazard -> all four flushes; the next cycle has pc_sel_trap=1 with if_id_flush; no load-use stall occurs.
REQ-025 Reset mid-MEM_WAIT: nrst=0 for 1 cycle -> all outputs 0, then RUN. With PIPE_HAZ_PERF_EN defined, 10 stall cycles -> stall_cnt=10; with it undefined, stall_cnt=0.
